// File: rtl/switch_allocator.sv
// Five-port wormhole switch allocator: each output runs an IDLE/LOCKED FSM with
// round-robin arbitration and holds its grant until the packet's tail transfers.

module sa_out_fsm (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] req_i,
    input  logic       xfer_i,
    input  logic       last_i,
    output logic       locked_o,
    output logic [2:0] owner_o
);
    typedef enum logic {IDLE, LOCKED} state_t;

    state_t     state_q, state_d;
    logic [2:0] owner_q, owner_d;
    logic [2:0] rr_q, rr_d;
    logic       found;
    logic [2:0] win;
    logic [3:0] idx;

    // Round-robin search starting at rr_q, wrapping 4 -> 0.
    always_comb begin
        found = 1'b0;
        win   = 3'd0;
        idx   = 4'd0;
        for (int k = 0; k < 5; k++) begin
            idx = {1'b0, rr_q} + 4'(k);
            if (idx > 4'd4) idx = idx - 4'd5;
            if (!found && req_i[idx[2:0]]) begin
                found = 1'b1;
                win   = idx[2:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        case (state_q)
            IDLE: if (found) begin
                state_d = LOCKED;
                owner_d = win;
                rr_d    = (win == 3'd4) ? 3'd0 : win + 3'd1;
            end
            LOCKED: if (xfer_i && last_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= 3'd0;
            rr_q    <= 3'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
        end
    end

    assign locked_o = (state_q == LOCKED);
    assign owner_o  = owner_q;
endmodule

module switch_allocator #(
    parameter logic [1:0] HDR_FLIT  = 2'b10,
    parameter logic [1:0] BODY_FLIT = 2'b00,
    parameter logic [1:0] TAIL_FLIT = 2'b01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  in_valid,
    input  logic [24:0] in_req,
    input  logic [9:0]  in_type,
    input  logic [4:0]  out_ready,
    output logic [4:0]  in_pop,
    output logic [4:0]  out_valid,
    output logic [14:0] out_sel,
    output logic [4:0]  out_busy
);
    localparam int NP = 5;

    logic [NP-1:0]           locked, xfer, last, owned, hdr_ok;
    logic [NP-1:0][2:0]      owner;
    logic [NP-1:0][NP-1:0]   req_m;
    logic [1:0]              typ [NP];
    logic [4:0]              rq  [NP];

    always_comb begin
        hdr_ok = '0;
        for (int i = 0; i < NP; i++) begin
            typ[i]    = in_type[2*i +: 2];
            rq[i]     = in_req[5*i +: 5];
            hdr_ok[i] = in_valid[i] && (typ[i] == HDR_FLIT || typ[i] == 2'b11);
        end
    end

    // An input already holding an output may not win a second one.
    always_comb begin
        owned = '0;
        for (int j = 0; j < NP; j++)
            if (locked[j]) owned[owner[j]] = 1'b1;
    end

    always_comb begin
        in_pop = '0;
        for (int j = 0; j < NP; j++)
            if (xfer[j]) in_pop[owner[j]] = 1'b1;
    end

    for (genvar j = 0; j < NP; j++) begin : g_out
        for (genvar i = 0; i < NP; i++) begin : g_req
            assign req_m[j][i] = hdr_ok[i] && !owned[i] && (rq[i] == (5'b00001 << j));
        end

        assign xfer[j] = locked[j] && in_valid[owner[j]] && out_ready[j];
        // A body flit never releases the lock, even if codes were overridden to collide.
        assign last[j] = (typ[owner[j]] == TAIL_FLIT || typ[owner[j]] == 2'b11) &&
                         (typ[owner[j]] != BODY_FLIT);

        sa_out_fsm u_fsm (
            .clk      (clk),
            .rst      (rst),
            .req_i    (req_m[j]),
            .xfer_i   (xfer[j]),
            .last_i   (last[j]),
            .locked_o (locked[j]),
            .owner_o  (owner[j])
        );

        assign out_sel[3*j +: 3] = locked[j] ? owner[j] : 3'd7;
        assign out_valid[j]      = locked[j] && in_valid[owner[j]];
        assign out_busy[j]       = locked[j];
    end
endmodule

// File: tb/tb_switch_allocator.sv
// Directed and random stimulus for switch_allocator, checked every cycle against
// an array-based reference model of the per-output lock/round-robin rules.

module tb_switch_allocator;
    logic        clk, rst;
    logic [4:0]  in_valid, out_ready;
    logic [24:0] in_req;
    logic [9:0]  in_type;
    logic [4:0]  in_pop, out_valid, out_busy;
    logic [14:0] out_sel;

    int checks = 0;
    int errors = 0;

    bit m_lk[5], n_lk[5];
    int m_own[5], n_own[5], m_rr[5], n_rr[5];

    logic [4:0]  o_pop, o_busy, o_valid;
    logic [14:0] o_sel;

    switch_allocator dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_req    (in_req),
        .in_type   (in_type),
        .out_ready (out_ready),
        .in_pop    (in_pop),
        .out_valid (out_valid),
        .out_sel   (out_sel),
        .out_busy  (out_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] ftyp(input int i);
        logic [9:0] t;
        t = in_type >> (2*i);
        return t[1:0];
    endfunction

    function automatic logic [4:0] frq(input int i);
        logic [24:0] r;
        r = in_req >> (5*i);
        return r[4:0];
    endfunction

    task automatic set_in(input int i, input bit v, input logic [4:0] r, input logic [1:0] t);
        in_valid[i]      = v;
        in_req[5*i +: 5] = r;
        in_type[2*i +: 2] = t;
    endtask

    task automatic model_reset();
        for (int j = 0; j < 5; j++) begin
            m_lk[j] = 0; m_own[j] = 0; m_rr[j] = 0;
        end
    endtask

    // Expected outputs from the model's ownership table and the current inputs.
    task automatic mexp(output logic [4:0] v, output logic [4:0] b,
                        output logic [4:0] p, output logic [14:0] s);
        v = '0; b = '0; p = '0; s = 15'h7fff;
        for (int j = 0; j < 5; j++) begin
            if (m_lk[j]) begin
                b[j] = 1'b1;
                s[3*j +: 3] = 3'(m_own[j]);
                v[j] = in_valid[m_own[j]];
                if (v[j] && out_ready[j]) p[m_own[j]] = 1'b1;
            end
        end
    endtask

    task automatic mnext();
        bit owned[5];
        bit found;
        int o, i;
        for (int k = 0; k < 5; k++) owned[k] = 0;
        for (int j = 0; j < 5; j++) if (m_lk[j]) owned[m_own[j]] = 1;
        for (int j = 0; j < 5; j++) begin
            n_lk[j] = m_lk[j]; n_own[j] = m_own[j]; n_rr[j] = m_rr[j];
            if (m_lk[j]) begin
                o = m_own[j];
                if (in_valid[o] && out_ready[j] && (ftyp(o) == 2'b01 || ftyp(o) == 2'b11))
                    n_lk[j] = 0;
            end else begin
                found = 0;
                for (int k = 0; k < 5; k++) begin
                    i = (m_rr[j] + k) % 5;
                    if (!found && in_valid[i] && (ftyp(i) == 2'b10 || ftyp(i) == 2'b11) &&
                        frq(i) == 5'(1 << j) && !owned[i]) begin
                        found = 1;
                        n_lk[j] = 1; n_own[j] = i; n_rr[j] = (i + 1) % 5;
                    end
                end
            end
        end
    endtask

    // One clock cycle: check outputs mid-cycle, then advance model and DUT together.
    task automatic cyc();
        logic [4:0]  ev, eb, ep;
        logic [14:0] es;
        #1;
        mexp(ev, eb, ep, es);
        chk("out_valid", out_valid, ev);
        chk("out_busy", out_busy, eb);
        chk("out_sel", out_sel, es);
        chk("in_pop", in_pop, ep);
        o_pop = in_pop; o_busy = out_busy; o_valid = out_valid; o_sel = out_sel;
        mnext();
        @(posedge clk);
        for (int j = 0; j < 5; j++) begin
            m_lk[j] = n_lk[j]; m_own[j] = n_own[j]; m_rr[j] = n_rr[j];
        end
        #1;
    endtask

    task automatic all_idle();
        in_valid = '0; in_req = '0; in_type = '0; out_ready = '0;
    endtask

    initial begin
        int order[$];
        bit v2[10], v0[10];
        logic [1:0] t2[10];
        logic [4:0] rdy[10];
        logic [4:0] rq;

        rst = 1'b1;
        all_idle();
        model_reset();
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", out_busy, 0);
        chk("rst_pop", in_pop, 0);
        chk("rst_sel", out_sel, 15'h7fff);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Single header from L to E: locked and transferring the cycle after request.
        set_in(0, 1, 5'b00010, 2'b10);
        out_ready = 5'b00010;
        cyc();
        cyc();
        chk("single_sel", o_sel[5:3], 0);
        chk("single_valid", o_valid[1], 1);
        chk("single_pop", o_pop[0], 1);
        set_in(0, 1, 5'b00010, 2'b01);
        cyc();
        set_in(0, 0, 5'b00000, 2'b00);
        cyc();

        // Contention for L from inputs 1, 3, 4 (two-flit packets each).
        all_idle();
        out_ready = 5'b00001;
        set_in(1, 1, 5'b00001, 2'b10);
        set_in(3, 1, 5'b00001, 2'b10);
        set_in(4, 1, 5'b00001, 2'b10);
        for (int c = 0; c < 30 && in_valid != 5'b0; c++) begin
            cyc();
            for (int i = 1; i < 5; i++) begin
                if (o_pop[i]) begin
                    if (ftyp(i) == 2'b10) begin
                        order.push_back(i);
                        set_in(i, 1, 5'b00001, 2'b01);
                    end else begin
                        set_in(i, 0, 5'b00000, 2'b00);
                    end
                end
            end
        end
        chk("cont_count", order.size(), 3);
        if (order.size() == 3) begin
            chk("cont_g0", order[0], 1);
            chk("cont_g1", order[1], 3);
            chk("cont_g2", order[2], 4);
        end
        // Pointer has wrapped to 0, so input 0 beats input 1.
        set_in(0, 1, 5'b00001, 2'b11);
        set_in(1, 1, 5'b00001, 2'b11);
        cyc();
        cyc();
        chk("cont_rr0", o_sel[2:0], 0);
        set_in(0, 0, 5'b00000, 2'b00);
        cyc();
        cyc();
        chk("cont_rr1", o_sel[2:0], 1);
        set_in(1, 0, 5'b00000, 2'b00);
        cyc();

        // Wormhole hold on S with a 3-cycle stall; input 0 waits for the tail.
        all_idle();
        v2  = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
        t2  = '{2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00};
        rdy = '{5'h00, 5'h08, 5'h08, 5'h00, 5'h00, 5'h00, 5'h08, 5'h08, 5'h08, 5'h08};
        v0  = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1};
        for (int c = 0; c < 10; c++) begin
            set_in(2, v2[c], 5'b01000, t2[c]);
            set_in(0, v0[c], 5'b01000, 2'b10);
            out_ready = rdy[c];
            cyc();
            if (c >= 1 && c <= 7) chk("worm_hold", o_sel[11:9], 2);
            if (c == 8) chk("worm_gap", o_busy[3], 0);
            if (c == 9) chk("worm_next", o_sel[11:9], 0);
        end
        set_in(0, 1, 5'b01000, 2'b01);
        cyc();
        set_in(0, 0, 5'b00000, 2'b00);
        cyc();

        // Back-to-back single-flit packets to N alternate between inputs 0 and 1.
        all_idle();
        out_ready = 5'b10000;
        set_in(0, 1, 5'b10000, 2'b11);
        set_in(1, 1, 5'b10000, 2'b11);
        for (int c = 0; c < 8; c++) begin
            cyc();
            if (c % 2 == 1) chk("sflit_own", o_sel[14:12], ((c - 1) / 2) % 2);
            else            chk("sflit_idle", o_busy[4], 0);
        end
        all_idle();
        cyc();

        // Multi-hot request is ignored.
        set_in(0, 1, 5'b00110, 2'b10);
        out_ready = 5'b11111;
        for (int c = 0; c < 3; c++) begin
            cyc();
            chk("illegal_busy", o_busy, 0);
            chk("illegal_pop", o_pop, 0);
        end
        all_idle();
        cyc();

        // Asynchronous reset while E is locked and transferring.
        set_in(0, 1, 5'b00010, 2'b10);
        cyc();
        set_in(0, 1, 5'b00010, 2'b00);
        out_ready = 5'b00010;
        #1;
        chk("arst_pre_pop", in_pop[0], 1);
        rst = 1'b1;
        #1;
        chk("arst_busy", out_busy, 0);
        chk("arst_valid", out_valid, 0);
        chk("arst_pop", in_pop, 0);
        chk("arst_sel", out_sel, 15'h7fff);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        set_in(0, 1, 5'b00010, 2'b10);
        cyc();
        chk("arst_rel_pop", o_pop, 0);
        chk("arst_rel_busy", o_busy, 0);
        set_in(0, 1, 5'b00010, 2'b01);
        cyc();
        cyc();
        all_idle();
        cyc();

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 5; i++) begin
                rq = ($urandom % 5 != 0) ? 5'(5'b00001 << ($urandom % 5)) : 5'($urandom);
                set_in(i, ($urandom % 4) != 0, rq, 2'($urandom));
            end
            out_ready = 5'($urandom);
            cyc();
        end
        all_idle();
        repeat (3) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
